gray_result_packer: RTL and testbench

Reader for the image pipeline's result FIFO. It drains the 32-bit grey words {8'h00, Y, Y, Y} from a standard (non-FWFT, 1-cycle read latency) FIFO and keeps one Y byte per word. It packs four pixels into each 32-bit host word and tags each word with end-of-line and end-of-frame flags. Downstream is a valid/ready host stream.

---
 rtl/gray_pack_pkg.sv | 20 ++
 rtl/gray_pack_pos_cnt.sv | 45 ++++
 rtl/gray_result_packer.sv | 129 ++++++++++++
 tb/tb_gray_result_packer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pack_pkg.sv
// gray_pack_pkg: shared constants and types for the grey result packer.
// Four 8-bit luma samples are packed into one 32-bit host word.
package gray_pack_pkg;

  localparam int PIX_W  = 8;
  localparam int PACK_N = 4;
  localparam int WORD_W = PIX_W * PACK_N;

  // Upper byte of a FIFO grey word; it must always read back as zero.
  localparam logic [31:0] MARK_MASK = 32'hFF00_0000;

  // Number of bytes already sitting in the pack shift register.
  typedef logic [$clog2(PACK_N)-1:0] pack_cnt_t;

  // Bytes held plus the byte in flight, modulo PACK_N (natural wrap).
  function automatic pack_cnt_t pack_sum(input pack_cnt_t cnt, input logic rd_q);
    return cnt + pack_cnt_t'(rd_q);
  endfunction

endpackage

// File: rtl/gray_pack_pos_cnt.sv
// gray_pack_pos_cnt: column/line position of the next packed word and the
// end-of-line / end-of-frame flags for the word currently being completed.
module gray_pack_pos_cnt
  import gray_pack_pkg::*;
#(
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic clk,
  input  logic srst,
  input  logic word_done,
  output logic word_eol,
  output logic word_eof
);

  localparam int COL_W  = $clog2(LINE_PIXELS);
  localparam int LINE_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;

  // col_reg holds the column of the first pixel of the next word, so the
  // word's last pixel is the line's last pixel when col_reg is at LINE_PIXELS-4.
  localparam logic [COL_W-1:0]  COL_LAST_WORD = COL_W'(LINE_PIXELS - PACK_N);
  localparam logic [LINE_W-1:0] LINE_LAST     = LINE_W'(FRAME_LINES - 1);

  logic [COL_W-1:0]  col_reg;
  logic [LINE_W-1:0] line_reg;

  assign word_eol = (col_reg == COL_LAST_WORD);
  assign word_eof = word_eol && (line_reg == LINE_LAST);

  // Advance the position by one word; wrap column at eol and everything at eof
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      col_reg  <= '0;
      line_reg <= '0;
    end else if (word_done) begin
      if (word_eol) begin
        col_reg  <= '0;
        line_reg <= word_eof ? '0 : line_reg + LINE_W'(1);
      end else begin
        col_reg  <= col_reg + COL_W'(PACK_N);
      end
    end
  end

endmodule

// File: rtl/gray_result_packer.sv
// gray_result_packer: drains {8'h00,Y,Y,Y} words from a 1-cycle-latency FIFO,
// keeps Y, packs four pixels per 32-bit host word (first pixel in [7:0]) and
// tags words with eol/eof on a valid/ready stream.
// Optional macro GRAY_PACKER_ERRCHK_EN: enables the sticky upper-byte
// marker check on err; when undefined err is constant 0.
module gray_result_packer
  import gray_pack_pkg::*;
#(
  parameter int LINE_PIXELS = 640,
  parameter int FRAME_LINES = 480
) (
  input  logic        clk,
  input  logic        srst,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_eol,
  output logic        dout_eof,
  output logic        frame_done,
  output logic        err
);

  generate
    if ((LINE_PIXELS < PACK_N) || (LINE_PIXELS % PACK_N != 0)) begin : g_bad_line_pixels
      $error("gray_result_packer: LINE_PIXELS must be a non-zero multiple of 4");
    end
    if (FRAME_LINES < 1) begin : g_bad_frame_lines
      $error("gray_result_packer: FRAME_LINES must be at least 1");
    end
  endgenerate

  localparam int        SHIFT_W   = PIX_W * (PACK_N - 1);
  localparam pack_cnt_t LAST_SLOT = pack_cnt_t'(PACK_N - 1);

  logic               rd_q_reg;
  pack_cnt_t          pack_cnt_reg;
  logic [SHIFT_W-1:0] shift_reg;
  logic [PIX_W-1:0]   pix;
  logic               word_done;
  logic               word_eol;
  logic               word_eof;
  logic               out_hs;

  assign pix       = fifo_dout[PIX_W-1:0];
  assign word_done = rd_q_reg && (pack_cnt_reg == LAST_SLOT);
  assign out_hs    = dout_valid && dout_ready;

  // A read that would become the 4th byte is only issued when the output
  // register is empty or draining now, so a completed word always has room.
  assign fifo_rd_en = !srst && !fifo_empty &&
                      ((pack_sum(pack_cnt_reg, rd_q_reg) != LAST_SLOT) ||
                       !dout_valid || dout_ready);

  // Track the in-flight read and shift captured bytes in from the top
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      rd_q_reg     <= 1'b0;
      pack_cnt_reg <= '0;
      shift_reg    <= '0;
    end else begin
      rd_q_reg <= fifo_rd_en;
      if (rd_q_reg) begin
        pack_cnt_reg <= pack_cnt_reg + pack_cnt_t'(1);
        shift_reg    <= {pix, shift_reg[SHIFT_W-1:PIX_W]};
      end
    end
  end

  gray_pack_pos_cnt #(
    .LINE_PIXELS (LINE_PIXELS),
    .FRAME_LINES (FRAME_LINES)
  ) u_pos_cnt (
    .clk       (clk),
    .srst      (srst),
    .word_done (word_done),
    .word_eol  (word_eol),
    .word_eof  (word_eof)
  );

  // Output register: a newly completed word wins over a same-cycle drain
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_eol   <= 1'b0;
      dout_eof   <= 1'b0;
    end else if (word_done) begin
      dout       <= {pix, shift_reg};
      dout_valid <= 1'b1;
      dout_eol   <= word_eol;
      dout_eof   <= word_eof;
    end else if (out_hs) begin
      dout_valid <= 1'b0;
    end
  end

  // One-cycle pulse after the end-of-frame word is accepted
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hs && dout_eof;
    end
  end

`ifdef GRAY_PACKER_ERRCHK_EN
  logic err_reg;

  // Sticky flag for any captured word whose marker byte is non-zero
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      err_reg <= 1'b0;
    end else if (rd_q_reg && |(fifo_dout & MARK_MASK)) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  logic unused_hi;

  assign err       = 1'b0;
  assign unused_hi = ^fifo_dout[31:PIX_W];
`endif

endmodule

// File: tb/tb_gray_result_packer.sv
// tb_gray_result_packer: directed bench for gray_result_packer with an
// 8-pixel line and a 2-line frame.
module tb_gray_result_packer;

  localparam int LP = 8;
  localparam int FL = 2;

`ifdef GRAY_PACKER_ERRCHK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        dout_eol;
  logic        dout_eof;
  logic        frame_done;
  logic        err;

  always #5 clk = ~clk;

  gray_result_packer #(
    .LINE_PIXELS (LP),
    .FRAME_LINES (FL)
  ) dut (
    .clk        (clk),
    .srst       (srst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_eol   (dout_eol),
    .dout_eof   (dout_eof),
    .frame_done (frame_done),
    .err        (err)
  );

  // Standard FIFO model: 1-cycle read latency, flushed by the shared reset
  logic [31:0] mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr;
  logic        gap = 1'b0;

  assign fifo_empty = (rd_ptr == wr_ptr) || gap;

  always @(posedge clk or posedge srst) begin
    if (srst) begin
      rd_ptr    <= wr_ptr;
      fifo_dout <= 32'h0;
    end else if (fifo_rd_en) begin
      rd_ptr    <= rd_ptr + 8'd1;
      fifo_dout <= mem[rd_ptr];
    end
  end

  // Monitor: read strobes, valid rises, accepted words, frame_done cycles
  int          cyc = 0;
  int          rd_cnt = 0;
  int          fd_cnt = 0;
  logic        v_prev = 1'b0;
  logic [33:0] out_q[$];
  int          rd_cyc[$];
  int          vrise_cyc[$];
  int          hs_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (!srst) begin
      if (fifo_rd_en) begin
        rd_cnt++;
        rd_cyc.push_back(cyc);
      end
      if (dout_valid && !v_prev) vrise_cyc.push_back(cyc);
      if (dout_valid && dout_ready) begin
        out_q.push_back({dout_eof, dout_eol, dout});
        hs_cyc.push_back(cyc);
      end
      if (frame_done) fd_cnt++;
    end
    v_prev = dout_valid;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic push_pix(input logic [7:0] p);
    push({8'h00, p, p, p});
  endtask

  task automatic wait_words(input int n, input int max_cyc);
    int k;
    k = 0;
    while (out_q.size() < n && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("wait_for_%0d_words", n), 32'(out_q.size() >= n), 32'd1);
  endtask

  task automatic chk_word(input int idx, input logic [31:0] exp_data,
                          input logic exp_eol, input logic exp_eof);
    logic [33:0] w;
    w = (idx < out_q.size()) ? out_q[idx] : '1;
    chk($sformatf("word%0d_data", idx), w[31:0], exp_data);
    chk($sformatf("word%0d_eol", idx), 32'(w[32]), 32'(exp_eol));
    chk($sformatf("word%0d_eof", idx), 32'(w[33]), 32'(exp_eof));
  endtask

  task automatic do_reset();
    @(negedge clk);
    srst = 1'b1;
    gap  = 1'b0;
    repeat (2) @(negedge clk);
    srst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ob;
    int rb;
    int vb;
    int hb;
    int r0;
    int f0;
    int k;
    logic [7:0] b;

    // ---- Reset state, with data already waiting in the FIFO ----
    repeat (3) @(negedge clk);
    push_pix(8'h01); push_pix(8'h02); push_pix(8'h03); push_pix(8'h04);
    #1;
    chk("rst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_dout_eol", 32'(dout_eol), 32'd0);
    chk("rst_dout_eof", 32'(dout_eof), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    ob = out_q.size(); rb = rd_cyc.size(); vb = vrise_cyc.size(); r0 = rd_cnt; f0 = fd_cnt;
    srst = 1'b0;
    #1;
    chk("first_rd_after_reset", 32'(fifo_rd_en), 32'd1);

    // ---- Packing order and latency ----
    wait_words(ob + 1, 20);
    chk_word(ob, 32'h04030201, 1'b0, 1'b0);
    chk("latency_rd4_to_valid",
        (rd_cyc.size() >= rb + 4 && vrise_cyc.size() >= vb + 1) ?
          32'(vrise_cyc[vb] - rd_cyc[rb + 3]) : 32'hFFFF_FFFF, 32'd2);
    chk("reads_first_word", 32'(rd_cnt - r0), 32'd4);

    // ---- Rest of frame 0: eol on words 2 and 4, eof on word 4 ----
    @(negedge clk);
    hb = hs_cyc.size();
    for (int i = 5; i <= 16; i++) push_pix(8'(i));
    wait_words(ob + 4, 60);
    chk_word(ob + 1, 32'h08070605, 1'b1, 1'b0);
    chk_word(ob + 2, 32'h0C0B0A09, 1'b0, 1'b0);
    chk_word(ob + 3, 32'h100F0E0D, 1'b1, 1'b1);
    chk("throughput_w2_w3",
        (hs_cyc.size() >= hb + 3) ? 32'(hs_cyc[hb + 1] - hs_cyc[hb]) : 32'hFFFF_FFFF, 32'd4);
    chk("throughput_w3_w4",
        (hs_cyc.size() >= hb + 3) ? 32'(hs_cyc[hb + 2] - hs_cyc[hb + 1]) : 32'hFFFF_FFFF, 32'd4);
    repeat (3) @(negedge clk);
    chk("frame_done_cycles", 32'(fd_cnt - f0), 32'd1);

    // ---- Next frame restarts at column 0, line 0 ----
    for (int i = 17; i <= 24; i++) push_pix(8'(i));
    wait_words(ob + 6, 60);
    chk_word(ob + 4, 32'h14131211, 1'b0, 1'b0);
    chk_word(ob + 5, 32'h18171615, 1'b1, 1'b0);
    chk("frame_done_not_repeated", 32'(fd_cnt - f0), 32'd1);

    // ---- Backpressure: 3 extra reads then stall, nothing lost ----
    do_reset();
    dout_ready = 1'b0;
    ob = out_q.size(); r0 = rd_cnt;
    for (int i = 8'h21; i <= 8'h2C; i++) push_pix(8'(i));
    repeat (20) @(negedge clk);
    chk("bp_reads_while_stalled", 32'(rd_cnt - r0), 32'd7);
    chk("bp_fifo_rd_en_low", 32'(fifo_rd_en), 32'd0);
    chk("bp_dout_valid_held", 32'(dout_valid), 32'd1);
    chk("bp_dout_held", dout, 32'h24232221);
    chk("bp_no_handshake", 32'(out_q.size() - ob), 32'd0);
    dout_ready = 1'b1;
    wait_words(ob + 3, 60);
    chk_word(ob, 32'h24232221, 1'b0, 1'b0);
    chk_word(ob + 1, 32'h28272625, 1'b1, 1'b0);
    chk_word(ob + 2, 32'h2C2B2A29, 1'b0, 1'b0);
    chk("bp_total_reads", 32'(rd_cnt - r0), 32'd12);

    // ---- Asynchronous reset mid-cycle with a held word and a partial word ----
    dout_ready = 1'b0;
    for (int i = 8'h31; i <= 8'h36; i++) push_pix(8'(i));
    repeat (15) @(negedge clk);
    chk("pre_arst_valid", 32'(dout_valid), 32'd1);
    @(posedge clk);
    #2;
    srst = 1'b1;
    #1;
    chk("arst_dout_valid", 32'(dout_valid), 32'd0);
    chk("arst_dout", dout, 32'h0);
    chk("arst_eol", 32'(dout_eol), 32'd0);
    chk("arst_fifo_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    srst = 1'b0;
    dout_ready = 1'b1;
    ob = out_q.size(); r0 = rd_cnt;
    for (int i = 8'h41; i <= 8'h44; i++) push_pix(8'(i));
    wait_words(ob + 1, 30);
    chk_word(ob, 32'h44434241, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("arst_reads_after", 32'(rd_cnt - r0), 32'd4);

    // ---- Random FIFO-empty gaps over 64 pixels ----
    do_reset();
    ob = out_q.size(); f0 = fd_cnt;
    for (int i = 0; i < 64; i++) push_pix(8'(8'h80 + i));
    k = 0;
    while (out_q.size() < ob + 16 && k < 800) begin
      @(negedge clk);
      gap = 1'($urandom_range(0, 1));
      k++;
    end
    gap = 1'b0;
    wait_words(ob + 16, 10);
    for (int w = 0; w < 16; w++) begin
      b = 8'(8'h80 + 4 * w);
      chk_word(ob + w, {b + 8'd3, b + 8'd2, b + 8'd1, b}, 1'((w % 2) == 1), 1'((w % 4) == 3));
    end
    repeat (3) @(negedge clk);
    chk("gap_frame_done_count", 32'(fd_cnt - f0), 32'd4);

    // ---- Marker-byte error flag ----
    do_reset();
    ob = out_q.size();
    push(32'h0000AB55); push(32'h00000066); push(32'h00000077); push(32'h00000088);
    wait_words(ob + 1, 30);
    chk_word(ob, 32'h88776655, 1'b0, 1'b0);
    chk("err_clean_marker", 32'(err), 32'd0);
    push(32'h5A000011); push(32'h00000022); push(32'h00000033); push(32'h00000044);
    wait_words(ob + 2, 30);
    chk_word(ob + 1, 32'h44332211, 1'b1, 1'b0);
    chk("err_after_marker", 32'(err), 32'(ERR_EXP));
    for (int i = 8'h51; i <= 8'h54; i++) push_pix(8'(i));
    wait_words(ob + 3, 30);
    repeat (5) @(negedge clk);
    chk_word(ob + 2, 32'h54535251, 1'b0, 1'b0);
    chk("err_sticky", 32'(err), 32'(ERR_EXP));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
